debug_commit_tracker: RTL

//  Sits between the core's writeback stage and the simulation Debug block. Turns raw

---
 rtl/debug_commit_tracker.sv | 132 +++++++++++++
 1 files changed

// File: rtl/debug_commit_tracker.sv
// rtl/debug_commit_tracker.sv - retire-event to debugInfo record tracker with one-retire delay
// Classifies device accesses, detects ebreak halt and runs a no-retire watchdog.
module debug_commit_tracker #(
    parameter logic [31:0] PMEM_BASE = 32'h8000_0000,
    parameter logic [31:0] PMEM_SIZE = 32'h0800_0000,
    parameter logic [31:0] TIMEOUT   = 32'd1_000_000,
    parameter int          CNT_W     = 64,
    parameter logic [31:0] RESET_PC  = 32'h8000_0000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic [31:0]      wb_pc,
    input  logic [31:0]      wb_inst,
    input  logic             wb_memEn,
    input  logic [31:0]      wb_memAddr,
    output logic             debug_debugInfo_valid,
    output logic             debug_debugInfo_halt,
    output logic             debug_debugInfo_deviceAccess,
    output logic [31:0]      debug_debugInfo_deviceAddr,
    output logic [31:0]      debug_debugInfo_pc,
    output logic             debug_timeout,
    output logic             debug_protoErr,
    output logic [CNT_W-1:0] debug_instCount
);

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_HOLD   = 2'd1,
        S_FLUSH  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [32:0] PMEM_LO = {1'b0, PMEM_BASE};
    localparam logic [32:0] PMEM_HI = {1'b0, PMEM_BASE} + {1'b0, PMEM_SIZE};
    localparam logic [31:0] WDOG_LAST = TIMEOUT - 32'd1;

    state_t      r_state;
    logic        r_hold_dev;
    logic [31:0] r_hold_addr;
    logic [31:0] r_hold_pc;
    logic [31:0] r_last_pc;
    logic [31:0] r_wdog;

    logic [32:0] w_addr33;
    logic        w_dev;
    logic        w_ebreak;
    logic        w_wdog_on;
    logic        w_wdog_fire;

    // 33-bit compare keeps PMEM_BASE+PMEM_SIZE from wrapping at the top of the map
    assign w_addr33    = {1'b0, wb_memAddr};
    assign w_dev       = wb_memEn & ((w_addr33 < PMEM_LO) | (w_addr33 >= PMEM_HI));
    assign w_ebreak    = (wb_inst == 32'h0010_0073);
    assign w_wdog_on   = (TIMEOUT != 32'd0);
    assign w_wdog_fire = w_wdog_on & ~wb_valid & (r_wdog == WDOG_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state                      <= S_EMPTY;
            r_hold_dev                   <= 1'b0;
            r_hold_addr                  <= 32'd0;
            r_hold_pc                    <= 32'd0;
            r_last_pc                    <= RESET_PC;
            r_wdog                       <= 32'd0;
            debug_debugInfo_valid        <= 1'b0;
            debug_debugInfo_halt         <= 1'b0;
            debug_debugInfo_deviceAccess <= 1'b0;
            debug_debugInfo_deviceAddr   <= 32'd0;
            debug_debugInfo_pc           <= 32'd0;
            debug_timeout                <= 1'b0;
            debug_protoErr               <= 1'b0;
            debug_instCount              <= '0;
        end else begin
            debug_debugInfo_valid        <= 1'b0;
            debug_debugInfo_halt         <= 1'b0;
            debug_debugInfo_deviceAccess <= 1'b0;
            debug_debugInfo_deviceAddr   <= 32'd0;
            debug_debugInfo_pc           <= 32'd0;
            case (r_state)
                S_EMPTY, S_HOLD: begin
                    if (wb_valid) begin
                        if (r_state == S_HOLD) begin
                            debug_debugInfo_valid        <= 1'b1;
                            debug_debugInfo_deviceAccess <= r_hold_dev;
                            debug_debugInfo_deviceAddr   <= r_hold_addr;
                            debug_debugInfo_pc           <= wb_pc;
                        end
                        r_hold_dev      <= w_dev;
                        r_hold_addr     <= w_dev ? wb_memAddr : 32'd0;
                        r_hold_pc       <= wb_pc;
                        r_last_pc       <= wb_pc;
                        r_wdog          <= 32'd0;
                        debug_instCount <= debug_instCount + {{(CNT_W-1){1'b0}}, 1'b1};
                        r_state         <= w_ebreak ? S_FLUSH : S_HOLD;
                    end else if (w_wdog_fire) begin
                        debug_debugInfo_valid <= 1'b1;
                        debug_debugInfo_halt  <= 1'b1;
                        debug_timeout         <= 1'b1;
                        if (r_state == S_HOLD) begin
                            debug_debugInfo_deviceAccess <= r_hold_dev;
                            debug_debugInfo_deviceAddr   <= r_hold_addr;
                            debug_debugInfo_pc           <= r_hold_pc;
                        end else begin
                            debug_debugInfo_pc <= r_last_pc;
                        end
                        r_state <= S_HALTED;
                    end else if (w_wdog_on) begin
                        r_wdog <= r_wdog + 32'd1;
                    end
                end
                S_FLUSH: begin
                    debug_debugInfo_valid        <= 1'b1;
                    debug_debugInfo_halt         <= 1'b1;
                    debug_debugInfo_deviceAccess <= r_hold_dev;
                    debug_debugInfo_deviceAddr   <= r_hold_addr;
                    debug_debugInfo_pc           <= r_hold_pc;
                    if (wb_valid) begin
                        debug_protoErr <= 1'b1;
                    end
                    r_state <= S_HALTED;
                end
                default: begin
                    if (wb_valid) begin
                        debug_protoErr <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
